// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared default geometry and drive rule for the word memory
package memory_pkg;

    localparam int MEM_AWIDTH = 5;
    localparam int MEM_DWIDTH = 8;

    // Read drive is suppressed whenever a write is requested, so the bus is free for write data
    function automatic logic read_drive(input logic rd, input logic wr);
        return rd && !wr;
    endfunction

endpackage

// File: rtl/memory_if.sv
// rtl/memory_if.sv - control and address bundle for the word memory
interface memory_if
    import memory_pkg::*;
#(
    parameter int AWIDTH = MEM_AWIDTH
);

    logic              wr;
    logic              rd;
    logic [AWIDTH-1:0] addr;

    modport master (output wr, output rd, output addr);
    modport slave  (input  wr, input  rd, input  addr);

endinterface

// File: rtl/memory.sv
// rtl/memory.sv - 2**AWIDTH x DWIDTH register-file memory on a shared tristate data bus
module memory
    import memory_pkg::*;
#(
    parameter int AWIDTH = MEM_AWIDTH,
    parameter int DWIDTH = MEM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    memory_if.slave           bus,
    inout  wire  [DWIDTH-1:0] data
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Reset clears every word at once; this is why storage is flops rather than a RAM macro
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.wr) begin
            mem[bus.addr] <= data;
        end
    end

    assign data = read_drive(bus.rd, bus.wr) ? mem[bus.addr] : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed and randomized self-checking bench for memory
module tb_memory;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tb_drv;
    logic [DW-1:0] tb_data;
    wire  [DW-1:0] data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];

    memory_if #(.AWIDTH(AW)) bus ();

    memory #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .data  (data)
    );

    assign data = tb_drv ? tb_data : {DW{1'bz}};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a;
        tb_drv = 1'b1; tb_data = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0; tb_drv = 1'b0;
        if (rst_n) ref_mem[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a);
        @(negedge clk);
        bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
        #1;
        chk($sformatf("%s[%0d]", tag, a), data, ref_mem[a]);
        bus.rd = 1'b0;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    initial begin
        rst_n = 1'b0; tb_drv = 1'b0; tb_data = '0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0;
        clear_ref();

        // read while held in reset returns zero
        #12;
        do_read("rst_read", 5'd4);

        // write on the first rising edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr = 1'b1; bus.addr = 5'd7; tb_drv = 1'b1; tb_data = 8'h77;
        @(posedge clk);
        #1;
        bus.wr = 1'b0; tb_drv = 1'b0;
        ref_mem[7] = 8'h77;
        do_read("first_wr", 5'd7);

        // boundary addresses
        do_write(5'd0, 8'hFF);
        do_write(5'd31, 8'h00);
        do_read("addr_lo", 5'd0);
        do_read("addr_hi", 5'd31);

        // descending address fill, no aliasing
        for (int i = 31; i >= 1; i--) do_write(AW'(i), DW'(31 - i));
        for (int i = 31; i >= 1; i--) chk_fill: begin
            do_read("fill", AW'(i));
        end

        // idle bus is released: bench pulls to 0 while addr 0 holds 8'h00 after fill? use a nonzero word
        do_write(5'd0, 8'hFF);
        @(negedge clk);
        bus.addr = 5'd0; bus.rd = 1'b0; bus.wr = 1'b0; tb_drv = 1'b1; tb_data = 8'h00;
        #1;
        chk("hiz_idle", data, 8'h00);
        tb_drv = 1'b0;
        bus.rd = 1'b1;
        #1;
        chk("rd_same_cycle", data, 8'hFF);

        // address change while reading is followed combinationally
        bus.addr = 5'd31;
        #1;
        chk("addr_follow31", data, ref_mem[31]);
        bus.addr = 5'd30;
        #1;
        chk("addr_follow30", data, ref_mem[30]);
        bus.rd = 1'b0;

        // write wins over read; old word is the complement so any drive corrupts the bus
        do_write(5'd5, 8'h5A);
        @(negedge clk);
        bus.addr = 5'd5; bus.wr = 1'b1; bus.rd = 1'b1; tb_drv = 1'b1; tb_data = 8'hA5;
        #1;
        chk("wr_rd_nodrive", data, 8'hA5);
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0; tb_drv = 1'b0;
        ref_mem[5] = 8'hA5;
        do_read("wr_rd_stored", 5'd5);

        // randomized traffic against the reference array
        for (int n = 0; n < 200; n++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'($urandom_range(DEPTH - 1, 0));
            d = DW'($urandom);
            if ($urandom_range(1, 0) == 1) do_write(a, d);
            else do_read("rand", a);
        end

        // asynchronous reset clears storage before the next edge
        do_write(5'd3, 8'h3C);
        do_read("pre_rst", 5'd3);
        @(negedge clk);
        bus.addr = 5'd3; bus.rd = 1'b1;
        #2;
        rst_n = 1'b0;
        clear_ref();
        #1;
        chk("async_rst", data, 8'h00);
        bus.rd = 1'b0;

        // writes are ignored while reset is held across an edge
        @(negedge clk);
        bus.wr = 1'b1; bus.addr = 5'd9; tb_drv = 1'b1; tb_data = 8'hEE;
        @(posedge clk);
        #1;
        bus.wr = 1'b0; tb_drv = 1'b0;
        do_read("rst_wr_ign", 5'd9);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) do_read("post_rst", AW'(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter AWIDTH, default 5: address width; depth SHALL be 2**AWIDTH words.
REQ-002 Parameter DWIDTH, default 8: data word width.
REQ-003 clk  input  1: single clock; all writes occur on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 wr  input  1: write enable, sampled at rising clk.
REQ-006 rd  input  1: read enable, output-drive control.
REQ-007 addr  input  AWIDTH: word address, shared by read and write.
REQ-008 data  inout  DWIDTH: bidirectional data bus; write data in, read data out.

Function
REQ-009 Storage SHALL be an array of 2**AWIDTH words of DWIDTH bits.
REQ-010 On rising clk with rst_n=1 and wr=1, mem[addr] SHALL be loaded from data.
REQ-011 A write SHALL affect only the addressed word; all other words keep their values.
REQ-012 When rd=1 and wr=0, the block SHALL drive data with mem[addr] combinationally (no clock latency).
REQ-013 When rd=0 or wr=1, the block SHALL keep data at high impedance on all DWIDTH bits.
REQ-014 wr=1 with rd=1: the write SHALL take priority, data SHALL NOT be driven, and the write SHALL complete normally.
REQ-015 When addr changes while reading, data SHALL follow the new word in the same cycle.
REQ-016 A read in the cycle after a write to the same address SHALL return the new value.
REQ-017 All 2**AWIDTH addresses SHALL be valid, including all-zeros and all-ones; there SHALL be no wrap-around or out-of-range handling.
REQ-018 X or Z on data during a write SHALL be stored as-is; no checking is required.

Reset
REQ-019 rst_n=0 SHALL clear every word to 0 immediately, without waiting for a clock edge.
REQ-020 While rst_n=0, writes SHALL be ignored.
REQ-021 While rst_n=0, the data drive rule of REQ-012/REQ-013 SHALL still apply, so a read returns 0.
REQ-022 A write on the first rising clk after rst_n deasserts SHALL be honoured.

Structure
REQ-023 Default AWIDTH/DWIDTH values SHALL be constants in the shared CPU package; the module SHALL override them via parameters.
REQ-024 No sub-module is required; tristate drive and storage SHALL live in memory.

Verification
REQ-025 Bench: write addr=00000 data=11111111, then addr=11111 data=00000000 -> reads return 11111111 and 00000000 respectively.
REQ-026 Bench: write data 0,1,2,... to addresses 31 down to 1 -> reading 31..1 returns 0,1,2,... with no aliasing.
REQ-027 Bench: wr=0, rd=0 -> data reads 'z on all bits; rd=1 -> data is driven within the same cycle.
REQ-028 Bench: wr=1, rd=1, addr=5, bench drives 8'hA5 -> memory does not drive data; a later read of addr 5 returns 8'hA5.
REQ-029 Bench: fill addr 3=8'h3C, pulse rst_n low mid-cycle -> a read of addr 3 returns 8'h00 before the next clk edge.
REQ-030 Bench: assert rst_n=0 with wr=1 across a clk edge -> no word changes; all reads return 0.
